// File: rtl/pipeline_pkg.sv
// Shared pipeline control types: forward-select encodings and the
// per-stage {rd, we, ld} record used by hazard/forwarding blocks.
package pipeline_pkg;

  // Register index width carried in stage_info_t; must match REG_W.
  localparam int RD_W = 3;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_REG = 2'd0;
  localparam fwd_t FWD_ALU = 2'd1;
  localparam fwd_t FWD_MEM = 2'd2;
  localparam fwd_t FWD_WB  = 2'd3;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            we;
    logic            ld;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_select.sv
// Operand forward-source selector for one decode-stage operand.
// Ports: i_rs/i_use (operand), i_ex/i_mem/i_wb (shadow stages), o_sel.
module fwd_select
  import pipeline_pkg::*;
(
  input  logic [RD_W-1:0] i_rs,
  input  logic            i_use,
  input  stage_info_t     i_ex,
  input  stage_info_t     i_mem,
  input  stage_info_t     i_wb,
  output fwd_t            o_sel
);

  logic w_live;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_live    = i_use && (i_rs != '0);
  // A load in EX has no data yet; it is covered by the stall instead.
  assign w_ex_hit  = i_ex.we && !i_ex.ld && (i_ex.rd == i_rs);
  assign w_mem_hit = i_mem.we && (i_mem.rd == i_rs);
  assign w_wb_hit  = i_wb.we && (i_wb.rd == i_rs);

  // Youngest producer wins.
  always_comb begin
    o_sel = FWD_REG;
    if (w_live) begin
      if (w_ex_hit)       o_sel = FWD_ALU;
      else if (w_mem_hit) o_sel = FWD_MEM;
      else if (w_wb_hit)  o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: shadow EX/MEM/WB pipeline, load-use
// stall, operand forward selects, writeback port and stall counter.
// Ports: clk, reset (async high), id_* decode info, flush;
//   ForwardA/B, stall, RD4, WB_signals, stall_count.
module hazard_forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             stall,
  output logic [REG_W-1:0] RD4,
  output logic             WB_signals,
  output logic [CNT_W-1:0] stall_count
);

  stage_info_t r_ex;
  stage_info_t r_mem;
  stage_info_t r_wb;
  logic [CNT_W-1:0] r_cnt;

  stage_info_t w_id;
  logic w_hit_a;
  logic w_hit_b;
  logic w_stall;
  logic w_accept;

  assign w_id.rd = id_rd;
  assign w_id.we = id_reg_write;
  assign w_id.ld = id_mem_read;

  assign w_hit_a = id_use_a && (id_rs_a == r_ex.rd);
  assign w_hit_b = id_use_b && (id_rs_b == r_ex.rd);

  // Flush kills the ID instruction, so it can never request a stall.
  assign w_stall = r_ex.ld && r_ex.we && (r_ex.rd != '0)
                && id_valid && !flush
                && (w_hit_a || w_hit_b);

  assign w_accept = id_valid && !w_stall && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex  <= STAGE_BUBBLE;
      r_mem <= STAGE_BUBBLE;
      r_wb  <= STAGE_BUBBLE;
    end else begin
      r_ex  <= w_accept ? w_id : STAGE_BUBBLE;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  fwd_select u_fwd_a (
    .i_rs  (id_rs_a),
    .i_use (id_use_a),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (ForwardA)
  );

  fwd_select u_fwd_b (
    .i_rs  (id_rs_b),
    .i_use (id_use_b),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (ForwardB)
  );

  assign stall       = w_stall;
  assign RD4         = r_wb.rd;
  assign WB_signals  = r_wb.we;
  assign stall_count = r_cnt;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller for the 16-bit five-stage processor. It tracks the destination register and write/load attributes of the instructions in EX, MEM and WB in its own shadow pipeline. From these it drives the ForwardA/ForwardB select and the stall to the decode stage. It also drives the register-file write port controls (RD4, WB_signals), making it the producing end of the decode stage's forwarding and writeback interface.

## Interface
Parameters:
- REG_W, 3, register-index width (8 GPRs; R0 reads as zero and is never forwarded).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock (single clock domain).
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs_a  in  REG_W  source register driving operand A.
- id_rs_b  in  REG_W  source register driving operand B.
- id_use_a  in  1  instruction reads A.
- id_use_b  in  1  instruction reads B.
- id_rd  in  REG_W  destination register (after RegDst selection, e.g. 7 for call).
- id_reg_write  in  1  instruction writes the register file.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  branch/jump taken; the instruction in ID is killed.
- ForwardA  out  2  operand A source: 0 regfile, 1 ALU result (EX), 2 memory result (MEM), 3 WB result.
- ForwardB  out  2  same encoding for operand B.
- stall  out  1  hold PC and IF/ID registers this cycle.
- RD4  out  REG_W  writeback destination register.
- WB_signals  out  1  register-file write enable for RD4.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Shadow stages EX, MEM, WB each hold: rd, we, ld. A bubble has we=0 and ld=0.
- Every cycle, without enable gating:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields if id_valid & !stall & !flush; otherwise EX <= bubble.
- Load-use hazard: stall = EX.ld & EX.we & EX.rd≠0 & id_valid & !flush & ((id_use_a & id_rs_a==EX.rd) | (id_use_b & id_rs_b==EX.rd)).
- Stall lasts exactly one cycle. The next cycle the load is in MEM and the operand forwards with code 2.
- Forward selection per operand, when the operand is used and its register is nonzero, in priority order:
  1. EX.we & !EX.ld & rd match → 1.
  2. MEM.we & rd match → 2.
  3. WB.we & rd match → 3.
  4. Otherwise → 0.
- An unused operand, or register 0, always selects 0.
- During stall, ForwardA/B still reflect the above logic; the decode-stage results are discarded.
- flush has priority over stall: a flushed ID never raises stall and enters EX as a bubble.
- RD4 = WB.rd; WB_signals = WB.we.
- stall_count increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- ForwardA, ForwardB and stall are combinational from ID inputs and registered shadow state, valid in the same cycle. They have no dependence on flush other than the stall gating above.
- An instruction accepted in cycle N is in EX.rd at N+1, MEM at N+2 and WB at N+3. RD4/WB_signals therefore present its write in cycle N+3.
- On reset assertion, immediately and asynchronously:
  - all shadow we/ld = 0 and rd = 0;
  - RD4 = 0, WB_signals = 0, stall_count = 0;
  - ForwardA = ForwardB = 0 and stall = 0 (pure consequence of the cleared state).
- Reset mid-stall discards the stalled instruction's pending state. After release, the first accepted instruction sees an empty pipeline.
- Back-to-back writers to the same rd: the youngest (EX) wins.
- Two loads in sequence followed by a use of the second: one stall only.

## Structure
- Shared package (pipeline_pkg) holds:
  - the 2-bit forward encodings FWD_REG, FWD_ALU, FWD_MEM, FWD_WB;
  - a stage_info struct {rd, we, ld} reused by other pipeline control blocks.
- Sub-module fwd_select, instantiated twice (A and B). Inputs: rs, use, EX/MEM/WB stage_info. Output: 2-bit select.
- The shadow pipeline, stall logic and counter stay in the top module.

## Test plan
- Reset: assert reset mid-run → all outputs 0 and stall_count=0 without waiting for a clock edge.
- ALU chain: ADD R1 write accepted at N, then at N+1 ID uses R1 as A → ForwardA=1. At N+2 the use → 2; at N+3 → 3 with RD4=1, WB_signals=1. At N+4 → 0.
- Load-use: LW R2 at N, ID uses R2 as B at N+1 → stall=1 for one cycle, EX bubble at N+2, ForwardB=2 at N+2, stall_count=1.
- R0 and unused operands: writer to R0 in EX, ID reads R0 → ForwardA=0. Writer to R3 with id_use_b=0 and rs_b=3 → ForwardB=0.
- Flush vs stall: load R4 in EX, ID uses R4, flush=1 → stall=0 and EX becomes a bubble (no WB_signals three cycles later).
- Priority and saturation: R5 written in EX, MEM and WB simultaneously → ForwardA=1. Force 2^16+3 stall cycles → stall_count=16'hFFFF.
